// File: rtl/mat4x4_tile_sched_pkg.sv
// Shared definitions for the tiled 4x4 matrix multiplier.
// Contents:
//   state_t       - controller states (IDLE, COMPUTE)
//   STEP_W        - width of the tile-product step counter
//   NUM_ELEMS     - number of elements in a flattened 4x4 matrix
//   elem_bit_off  - bit offset of element (r,c) in a flattened 4x4 matrix
//   tile_bit_off  - bit offset of element (i,j) of 2x2 tile (p,q) in a 4x4 matrix
//   sub_bit_off   - bit offset of element (i,j) in a flattened 2x2 tile
package mat4x4_tile_sched_pkg;

    localparam int STEP_W    = 3;
    localparam int MAT_N     = 4;
    localparam int NUM_ELEMS = MAT_N * MAT_N;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    function automatic int elem_bit_off(input int r, input int c, input int width);
        return (r * MAT_N + c) * width;
    endfunction

    function automatic int tile_bit_off(input int p, input int q, input int i, input int j,
                                        input int width);
        return elem_bit_off(2 * p + i, 2 * q + j, width);
    endfunction

    function automatic int sub_bit_off(input int i, input int j, input int width);
        return (i * 2 + j) * width;
    endfunction

endpackage

// File: rtl/mat4x4_tile_sched_if.sv
// Host-side bus of the tiled 4x4 matrix multiplier.
// Signals:
//   start - request, accepted only while the multiplier is idle
//   A, B  - flattened 4x4 operands, element (r,c) at [(r*4+c)*WIDTH +: WIDTH]
//   C     - flattened 4x4 registered result, same layout
//   busy  - high while a multiply is in progress
//   done  - one-cycle completion pulse, C valid from this cycle
// Modports: master (host side), slave (multiplier side).
interface mat4x4_tile_sched_if #(
    parameter int WIDTH = 16
);
    logic                  start;
    logic [WIDTH*16-1:0]   A;
    logic [WIDTH*16-1:0]   B;
    logic [WIDTH*16-1:0]   C;
    logic                  busy;
    logic                  done;

    modport master (output start, output A, output B, input C, input busy, input done);
    modport slave  (input start, input A, input B, output C, output busy, output done);

endinterface

// File: rtl/mat2x2_mult.sv
// Combinational 2x2 matrix multiplier, all arithmetic modulo 2^WIDTH.
// Ports:
//   a, b - flattened 2x2 operands, element (i,j) at [(i*2+j)*WIDTH +: WIDTH]
//   p    - flattened 2x2 product a*b, same layout
module mat2x2_mult #(
    parameter int WIDTH = 16
) (
    input  logic [4*WIDTH-1:0] a,
    input  logic [4*WIDTH-1:0] b,
    output logic [4*WIDTH-1:0] p
);

    // Each output element is a two-term dot product; the WIDTH-bit target
    // truncates products and sum, giving the wraparound behaviour directly.
    always_comb begin
        p = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                p[(i*2+j)*WIDTH +: WIDTH] =
                    a[(i*2)*WIDTH +: WIDTH]   * b[j*WIDTH +: WIDTH] +
                    a[(i*2+1)*WIDTH +: WIDTH] * b[(2+j)*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mat4x4_tile_sched.sv
// Sequenced 4x4 matrix multiplier built around one shared 2x2 tile multiplier.
// The eight tile products of C = A*B are issued one per clock, and pairs are
// accumulated into output tiles (0,0),(0,1),(1,0),(1,1) in that order.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - slave side of mat4x4_tile_sched_if (start, A, B, C, busy, done)
module mat4x4_tile_sched
    import mat4x4_tile_sched_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    mat4x4_tile_sched_if.slave bus
);

    localparam logic [STEP_W-1:0] LAST_STEP = '1;

    state_t                      state;
    state_t                      state_n;
    logic [STEP_W-1:0]           step;
    logic [NUM_ELEMS*WIDTH-1:0]  a_q;
    logic [NUM_ELEMS*WIDTH-1:0]  b_q;
    logic [NUM_ELEMS*WIDTH-1:0]  res_q;
    logic [NUM_ELEMS*WIDTH-1:0]  res_upd;
    logic [NUM_ELEMS*WIDTH-1:0]  c_q;
    logic [4*WIDTH-1:0]          acc;
    logic [4*WIDTH-1:0]          a_tile;
    logic [4*WIDTH-1:0]          b_tile;
    logic [4*WIDTH-1:0]          prod;
    logic                        busy_q;
    logic                        done_q;
    logic                        tp;
    logic                        tq;
    logic                        tk;

    assign tp = step[2];
    assign tq = step[1];
    assign tk = step[0];

    assign bus.C    = c_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: a run lasts exactly eight COMPUTE edges; any
    // unexpected encoding falls back to IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = COMPUTE;
            COMPUTE: if (step == LAST_STEP) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Select A tile (p,k) and B tile (k,q) from the latched operands.
    always_comb begin
        a_tile = '0;
        b_tile = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                a_tile[sub_bit_off(i, j, WIDTH) +: WIDTH] =
                    a_q[tile_bit_off(int'(tp), int'(tk), i, j, WIDTH) +: WIDTH];
                b_tile[sub_bit_off(i, j, WIDTH) +: WIDTH] =
                    b_q[tile_bit_off(int'(tk), int'(tq), i, j, WIDTH) +: WIDTH];
            end
        end
    end

    mat2x2_mult #(
        .WIDTH (WIDTH)
    ) u_tile_mult (
        .a (a_tile),
        .b (b_tile),
        .p (prod)
    );

    // Partial result with output tile (p,q) replaced by acc + P. On the last
    // step this already contains tile (1,1), so it is the complete result.
    always_comb begin
        res_upd = res_q;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                res_upd[tile_bit_off(int'(tp), int'(tq), i, j, WIDTH) +: WIDTH] =
                    acc[sub_bit_off(i, j, WIDTH) +: WIDTH] +
                    prod[sub_bit_off(i, j, WIDTH) +: WIDTH];
            end
        end
    end

    // Datapath and status registers. Tiles collect in res_q and C is only
    // loaded on the final step, so the host never sees a partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            res_q  <= '0;
            c_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        step   <= '0;
                        busy_q <= 1'b1;
                    end
                end
                COMPUTE: begin
                    step <= step + 1'b1;
                    if (!tk) begin
                        acc <= prod;
                    end else begin
                        res_q <= res_upd;
                    end
                    if (step == LAST_STEP) begin
                        c_q    <= res_upd;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    step   <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
